// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue/writeback sequencer sitting in front of the combinational alu.
// Decodes instructions, reads operands from a small register file, drives
// registered opcode/operands to the alu, then writes the alu result back and
// keeps a sticky copy of the alu flags.
// Optional feature macro: ALU_ISSUE_PIPE_EN (back-to-back issue with result
// forwarding). When it is undefined, one instruction is handled every 3 cycles.
module alu_issue_seq #(
  parameter int               DATA_W  = 8,
  parameter int               OPC_W   = 4,
  parameter int               REG_AW  = 2,
  parameter int               FLAG_W  = 3,
  parameter logic [OPC_W-1:0] NOP_OPC = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [16:0]       instr_data,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] operand_A,
  output logic [DATA_W-1:0] operand_B,
  input  logic [DATA_W-1:0] result,
  input  logic [FLAG_W-1:0] flag,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [FLAG_W-1:0] flag_q,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              ready_s;
  logic              accept_s;
  logic              fwd_en_s;
  logic [DATA_W-1:0] src_a_s;
  logic [DATA_W-1:0] src_b_s;
  logic [DATA_W-1:0] reg_r [NREG];
  logic [REG_AW-1:0] rd_r;
  logic              nop_r;

  // Instruction field decode.
  logic              b_imm_s;
  logic [OPC_W-1:0]  opc_s;
  logic [REG_AW-1:0] rd_s;
  logic [REG_AW-1:0] ra_s;
  logic [REG_AW-1:0] rb_s;
  logic [7:0]        imm_s;

  assign b_imm_s = instr_data[16];
  assign opc_s   = instr_data[12 +: OPC_W];
  assign rd_s    = instr_data[10 +: REG_AW];
  assign ra_s    = instr_data[8 +: REG_AW];
  assign rb_s    = instr_data[0 +: REG_AW];
  assign imm_s   = instr_data[7:0];

  // Next-state and ready decode for the issue FSM.
  always_comb begin
    state_s = state_r;
    ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (instr_valid) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
`ifdef ALU_ISSUE_PIPE_EN
      EXEC: begin
        // A new instruction can be taken while the current one writes back.
        ready_s = 1'b1;
        if (instr_valid) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
`else
      EXEC: begin
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
`endif
      default: begin
        state_s = IDLE;
        ready_s = 1'b0;
      end
    endcase
    accept_s = instr_valid & ready_s;
  end

  // Operand selection, with forwarding of the live alu result when enabled.
  always_comb begin
`ifdef ALU_ISSUE_PIPE_EN
    fwd_en_s = (state_r == EXEC) & ~nop_r;
`else
    fwd_en_s = 1'b0;
`endif
    if (fwd_en_s && (ra_s == rd_r)) begin
      src_a_s = result;
    end else begin
      src_a_s = reg_r[ra_s];
    end
    // The immediate path is never forwarded.
    if (b_imm_s) begin
      src_b_s = DATA_W'(imm_s);
    end else if (fwd_en_s && (rb_s == rd_r)) begin
      src_b_s = result;
    end else begin
      src_b_s = reg_r[rb_s];
    end
  end

  // State, operand, register-file and writeback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      opcode    <= {OPC_W{1'b0}};
      operand_A <= {DATA_W{1'b0}};
      operand_B <= {DATA_W{1'b0}};
      rd_r      <= {REG_AW{1'b0}};
      nop_r     <= 1'b0;
      wb_valid  <= 1'b0;
      wb_addr   <= {REG_AW{1'b0}};
      wb_data   <= {DATA_W{1'b0}};
      flag_q    <= {FLAG_W{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        reg_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_r  <= state_s;
      wb_valid <= 1'b0;
      if (accept_s) begin
        opcode    <= opc_s;
        operand_A <= src_a_s;
        operand_B <= src_b_s;
        rd_r      <= rd_s;
        nop_r     <= (opc_s == NOP_OPC);
      end
      // End of EXEC: the alu output reflects the operands loaded last edge.
      if ((state_r == EXEC) && !nop_r) begin
        reg_r[rd_r] <= result;
        flag_q      <= flag;
        wb_valid    <= 1'b1;
        wb_addr     <= rd_r;
        wb_data     <= result;
      end
    end
  end

  assign instr_ready = ready_s;
  assign busy        = (state_r != IDLE);
  assign dbg_data    = reg_r[dbg_addr];

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq with an adder alu model
// (result = A + B mod 256, flag = {carry, zero, sign}).
module tb_alu_issue_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [16:0] instr_data;
  logic [3:0]  opcode;
  logic [7:0]  operand_A;
  logic [7:0]  operand_B;
  logic [7:0]  result;
  logic [2:0]  flag;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [2:0]  flag_q;
  logic        busy;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic [8:0]  sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference alu.
  assign sum    = {1'b0, operand_A} + {1'b0, operand_B};
  assign result = sum[7:0];
  assign flag   = {sum[8], (sum[7:0] == 8'h00), sum[7]};

  alu_issue_seq dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .opcode      (opcode),
    .operand_A   (operand_A),
    .operand_B   (operand_B),
    .result      (result),
    .flag        (flag),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flag_q      (flag_q),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  task automatic drive(input logic bi, input logic [3:0] opc, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [7:0] imm);
    instr_data  = {bi, opc, rd, ra, imm};
    instr_valid = 1'b1;
  endtask

  // Offer one instruction for exactly one (accepting) edge.
  task automatic issue(input logic bi, input logic [3:0] opc, input logic [1:0] rd,
                       input logic [1:0] ra, input logic [7:0] imm);
    drive(bi, opc, rd, ra, imm);
    tick();
    instr_valid = 1'b0;
  endtask

  logic exec_ready_exp;
  logic wb_busy_exp;

  initial begin
`ifdef ALU_ISSUE_PIPE_EN
    exec_ready_exp = 1'b1;
    wb_busy_exp    = 1'b0;
`else
    exec_ready_exp = 1'b0;
    wb_busy_exp    = 1'b1;
`endif
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_data  = 17'h0;
    dbg_addr    = 2'd0;

    // 1. Reset values.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready",    {31'h0, instr_ready}, 32'h1);
    chk("rst_busy",     {31'h0, busy},        32'h0);
    chk("rst_wb_valid", {31'h0, wb_valid},    32'h0);
    chk("rst_wb_addr",  {30'h0, wb_addr},     32'h0);
    chk("rst_wb_data",  {24'h0, wb_data},     32'h0);
    chk("rst_opcode",   {28'h0, opcode},      32'h0);
    chk("rst_opA",      {24'h0, operand_A},   32'h0);
    chk("rst_opB",      {24'h0, operand_B},   32'h0);
    chk("rst_flag_q",   {29'h0, flag_q},      32'h0);
    for (int i = 0; i < 4; i++) begin
      dbg_chk("rst_dbg", 2'(i), 8'h00);
    end

    // 2. Immediate operand: r1 = r0 + 0x27.
    issue(1'b1, 4'b0100, 2'd1, 2'd0, 8'h27);
    chk("imm_opcode", {28'h0, opcode},      32'h4);
    chk("imm_opA",    {24'h0, operand_A},   32'h00);
    chk("imm_opB",    {24'h0, operand_B},   32'h27);
    chk("imm_busy",   {31'h0, busy},        32'h1);
    chk("imm_ready",  {31'h0, instr_ready}, {31'h0, exec_ready_exp});
    chk("imm_nowb",   {31'h0, wb_valid},    32'h0);
    tick();
    chk("imm_wbv",    {31'h0, wb_valid},    32'h1);
    chk("imm_wba",    {30'h0, wb_addr},     32'h1);
    chk("imm_wbd",    {24'h0, wb_data},     32'h27);
    chk("imm_flag",   {29'h0, flag_q},      32'h0);
    dbg_chk("imm_r1", 2'd1, 8'h27);
    tick();
    chk("imm_pulse",  {31'h0, wb_valid},    32'h0);
    chk("imm_idle",   {31'h0, busy},        32'h0);

    // Register operands: r2 = r1 + r1.
    issue(1'b0, 4'b0100, 2'd2, 2'd1, 8'h01);
    chk("reg_opA", {24'h0, operand_A}, 32'h27);
    chk("reg_opB", {24'h0, operand_B}, 32'h27);
    tick();
    chk("reg_wbv", {31'h0, wb_valid},  32'h1);
    chk("reg_wba", {30'h0, wb_addr},   32'h2);
    chk("reg_wbd", {24'h0, wb_data},   32'h4E);
    tick();

    // 3. Wrap and flags.
    issue(1'b1, 4'b0100, 2'd0, 2'd0, 8'h02);
    tick();
    chk("pre_wbd", {24'h0, wb_data}, 32'h02);
    tick();
    issue(1'b1, 4'b0100, 2'd3, 2'd0, 8'hFF);
    dbg_chk("wrap_old_r3", 2'd3, 8'h00);
    tick();
    chk("wrap_wbd",  {24'h0, wb_data}, 32'h01);
    chk("wrap_flag", {29'h0, flag_q},  32'h4);
    dbg_chk("wrap_new_r3", 2'd3, 8'h01);
    tick();
    issue(1'b1, 4'b0100, 2'd2, 2'd0, 8'hFE);
    tick();
    chk("zero_wbv",  {31'h0, wb_valid}, 32'h1);
    chk("zero_wbd",  {24'h0, wb_data},  32'h00);
    chk("zero_flag", {29'h0, flag_q},   32'h6);
    tick();

    // 4. NOP: no writeback, r3 and flag_q unchanged.
    issue(1'b1, 4'b0000, 2'd3, 2'd0, 8'h55);
    chk("nop_busy", {31'h0, busy},     32'h1);
    chk("nop_opc",  {28'h0, opcode},   32'h0);
    tick();
    chk("nop_wbv",   {31'h0, wb_valid}, 32'h0);
    chk("nop_busy2", {31'h0, busy},     {31'h0, wb_busy_exp});
    chk("nop_flag",  {29'h0, flag_q},   32'h6);
    dbg_chk("nop_r3", 2'd3, 8'h01);
    tick();
    chk("nop_idle", {31'h0, busy},     32'h0);
    chk("nop_wbv2", {31'h0, wb_valid}, 32'h0);

    // 5. Reset during EXEC discards the instruction.
    issue(1'b1, 4'b0100, 2'd0, 2'd0, 8'h33);
    chk("mid_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_wbv",  {31'h0, wb_valid}, 32'h0);
    chk("mid_busy2", {31'h0, busy},    32'h0);
    chk("mid_flag", {29'h0, flag_q},   32'h0);
    chk("mid_opB",  {24'h0, operand_B}, 32'h0);
    dbg_chk("mid_r0", 2'd0, 8'h00);
    tick();
    chk("mid_wbv2", {31'h0, wb_valid},    32'h0);
    chk("mid_ready", {31'h0, instr_ready}, 32'h1);
    dbg_chk("mid_r0b", 2'd0, 8'h00);

    // 6. Dependent adds r1 = r1 + 0x10, instr_valid held high.
    drive(1'b1, 4'b0100, 2'd1, 2'd1, 8'h10);
`ifdef ALU_ISSUE_PIPE_EN
    chk("b2b_ready0", {31'h0, instr_ready}, 32'h1);
    tick();
    chk("b2b_ready1", {31'h0, instr_ready}, 32'h1);
    tick();
    chk("b2b_wbv1", {31'h0, wb_valid},    32'h1);
    chk("b2b_wbd1", {24'h0, wb_data},     32'h10);
    chk("b2b_ready2", {31'h0, instr_ready}, 32'h1);
    tick();
    instr_valid = 1'b0;
    chk("b2b_wbv2", {31'h0, wb_valid},    32'h1);
    chk("b2b_wbd2", {24'h0, wb_data},     32'h20);
    tick();
    chk("b2b_wbv3", {31'h0, wb_valid},    32'h1);
    chk("b2b_wbd3", {24'h0, wb_data},     32'h30);
    tick();
    chk("b2b_end",  {31'h0, wb_valid},    32'h0);
`else
    for (int k = 0; k < 3; k++) begin
      chk("seq_ready_idle", {31'h0, instr_ready}, 32'h1);
      tick();
      if (k == 2) instr_valid = 1'b0;
      chk("seq_ready_exec", {31'h0, instr_ready}, 32'h0);
      chk("seq_nowb",       {31'h0, wb_valid},    32'h0);
      tick();
      chk("seq_ready_done", {31'h0, instr_ready}, 32'h0);
      chk("seq_wbv",        {31'h0, wb_valid},    32'h1);
      chk("seq_wbd",        {24'h0, wb_data},     32'(8'h10 * (k + 1)));
      tick();
    end
`endif
    dbg_chk("b2b_r1", 2'd1, 8'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
